// File: rtl/key_encoder.sv
// Keypad encoder: debounces the twelve key lines, rejects multi-key presses and
// issues one 4-bit key event per physical press through a one-entry valid/ready buffer.
module key_encoder #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] push,
    input  logic       mem,
    input  logic       cls,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       multi_err,
    output logic       overrun
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Index of the set bit; result is meaningless unless the input is one-hot.
    function automatic logic [3:0] encode(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic is_one_hot(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

    logic [11:0]      raw_s;
    logic             active_s;
    logic             match_s;
    logic             accept_s;
    logic             issue_s;
    logic [1:0]       state_r,  state_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [11:0]      snap_r,   snap_nxt_s;
    logic [3:0]       code_nxt_s;
    logic             valid_nxt_s;
    logic             ovr_nxt_s;
    logic             multi_nxt_s;

    assign raw_s    = {cls, mem, push};
    assign active_s = |raw_s;
    assign match_s  = (raw_s == snap_r);
    assign accept_s = (state_r == PRESS_DB) && match_s && (cnt_r == CNT_LAST);
    assign issue_s  = accept_s && is_one_hot(snap_r);

    // Debounce state machine next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        snap_nxt_s  = snap_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (active_s) begin
                    state_nxt_s = PRESS_DB;
                    snap_nxt_s  = raw_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS_DB: begin
                if (!match_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                cnt_nxt_s = CNT_ZERO;
                if (active_s) begin
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = REL_DB;
                end
            end
            REL_DB: begin
                if (active_s) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // One-entry output buffer: a same-cycle delivery frees the slot for a new event.
    always_comb begin
        code_nxt_s  = key_code;
        valid_nxt_s = key_valid;
        ovr_nxt_s   = overrun;
        multi_nxt_s = accept_s && !is_one_hot(snap_r);
        if (issue_s) begin
            if (!key_valid || key_ready) begin
                code_nxt_s  = encode(snap_r);
                valid_nxt_s = 1'b1;
            end else begin
                ovr_nxt_s = 1'b1;
            end
        end else if (key_valid && key_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = key_valid;
        end
    end

    // State, counter, snapshot and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            snap_r    <= 12'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            multi_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            snap_r    <= snap_nxt_s;
            key_code  <= code_nxt_s;
            key_valid <= valid_nxt_s;
            multi_err <= multi_nxt_s;
            overrun   <= ovr_nxt_s;
        end
    end

endmodule

// File: tb/tb_key_encoder.sv
// Directed self-checking bench for key_encoder with DB_CYCLES=16.
module tb_key_encoder;

    logic       CLK;
    logic       RST;
    logic [9:0] push;
    logic       mem;
    logic       cls;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       multi_err;
    logic       overrun;

    int vectors;
    int miscompares;

    key_encoder #(.DB_CYCLES(16), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .mem       (mem),
        .cls       (cls),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .multi_err (multi_err),
        .overrun   (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        int bad;
        RST = 1'b1;
        #1;
        vectors++;
        if ({key_valid, key_code, multi_err, overrun} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_async: got valid=%b code=%0d multi=%b ovr=%b, want all 0",
                     key_valid, key_code, multi_err, overrun);
        end
        tick(2);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            vectors++;
            if ({key_valid, key_code, multi_err, overrun} !== 7'd0) begin
                miscompares++;
                bad++;
                if (bad < 4)
                    $display("FAIL reset_idle: cycle %0d got valid=%b code=%0d multi=%b ovr=%b, want all 0",
                             i, key_valid, key_code, multi_err, overrun);
            end
        end
    endtask

    task automatic test_single_press;
        int first;
        int pulses;
        key_ready = 1'b1;
        push = 10'b00_1000_0000;
        first = 0;
        pulses = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (key_valid === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
                vectors++;
                if (key_code !== 4'd7) begin
                    miscompares++;
                    $display("FAIL single_code: got %0d, want 7", key_code);
                end
            end
        end
        vectors++;
        if (first != 17) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles, want 17", first);
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL single_pulses: got %0d, want 1", pulses);
        end
        push = 10'd0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (key_valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL single_release: got %0d pulses after release, want 0", pulses);
        end
    endtask

    task automatic test_glitch;
        int pulses;
        int first;
        key_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            push = (c % 2 == 0) ? 10'd8 : 10'd0;
            for (int k = 0; k < 5; k++) begin
                tick(1);
                if (key_valid === 1'b1) pulses++;
            end
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL glitch_toggle: got %0d events while toggling, want 0", pulses);
        end
        push = 10'd8;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (key_valid === 1'b1 && first == 0) begin
                first = i;
                vectors++;
                if (key_code !== 4'd3) begin
                    miscompares++;
                    $display("FAIL glitch_code: got %0d, want 3", key_code);
                end
            end
        end
        vectors++;
        if (first != 17) begin
            miscompares++;
            $display("FAIL glitch_latency: got %0d cycles, want 17", first);
        end
        push = 10'd0;
        tick(25);
    endtask

    task automatic test_back_to_back;
        key_ready = 1'b0;
        push = 10'd16;
        tick(17);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd4) begin
            miscompares++;
            $display("FAIL b2b_first: got valid=%b code=%0d, want 1/4", key_valid, key_code);
        end
        push = 10'd0;
        tick(25);
        push = 10'd64;
        tick(16);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd4) begin
            miscompares++;
            $display("FAIL b2b_hold: got valid=%b code=%0d, want 1/4", key_valid, key_code);
        end
        key_ready = 1'b1;
        tick(1);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd6 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_swap: got valid=%b code=%0d ovr=%b, want 1/6/0",
                     key_valid, key_code, overrun);
        end
        tick(1);
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got valid=%b, want 0", key_valid);
        end
        push = 10'd0;
        tick(25);
    endtask

    task automatic test_overrun;
        key_ready = 1'b0;
        mem = 1'b1;
        tick(17);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd10) begin
            miscompares++;
            $display("FAIL ovr_mem: got valid=%b code=%0d, want 1/10", key_valid, key_code);
        end
        mem = 1'b0;
        tick(25);
        cls = 1'b1;
        tick(16);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_early: got ovr=%b, want 0", overrun);
        end
        tick(1);
        vectors++;
        if (overrun !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'd10) begin
            miscompares++;
            $display("FAIL ovr_drop: got ovr=%b valid=%b code=%0d, want 1/1/10",
                     overrun, key_valid, key_code);
        end
        key_ready = 1'b1;
        tick(1);
        vectors++;
        if (key_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_deliver: got valid=%b ovr=%b, want 0/1", key_valid, overrun);
        end
        cls = 1'b0;
        tick(25);
    endtask

    task automatic test_multi;
        int highs;
        int at;
        int vcount;
        key_ready = 1'b0;
        push = 10'd6;
        highs = 0;
        at = 0;
        vcount = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (multi_err === 1'b1) begin
                highs++;
                if (at == 0) at = i;
            end
            if (key_valid === 1'b1) vcount++;
        end
        vectors++;
        if (highs != 1 || at != 17) begin
            miscompares++;
            $display("FAIL multi_pulse: got %0d high cycles first at %0d, want 1 at 17", highs, at);
        end
        vectors++;
        if (vcount != 0) begin
            miscompares++;
            $display("FAIL multi_noevent: got %0d valid cycles, want 0", vcount);
        end
        push = 10'd0;
        tick(25);
        push = 10'd4;
        tick(17);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd2) begin
            miscompares++;
            $display("FAIL multi_single: got valid=%b code=%0d, want 1/2", key_valid, key_code);
        end
        push = 10'd0;
        tick(25);
    endtask

    task automatic test_async_reset;
        push = 10'd32;
        tick(9);
        vectors++;
        if (key_valid !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: got valid=%b ovr=%b, want 1/1", key_valid, overrun);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if ({key_valid, key_code, multi_err, overrun} !== 7'd0) begin
            miscompares++;
            $display("FAIL rst_mid: got valid=%b code=%0d multi=%b ovr=%b, want all 0",
                     key_valid, key_code, multi_err, overrun);
        end
        tick(2);
        RST = 1'b0;
        tick(16);
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_redebounce_early: got valid=%b, want 0", key_valid);
        end
        tick(1);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd5) begin
            miscompares++;
            $display("FAIL rst_redebounce: got valid=%b code=%0d, want 1/5", key_valid, key_code);
        end
        push = 10'd0;
        tick(5);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST       = 1'b0;
        push      = 10'd0;
        mem       = 1'b0;
        cls       = 1'b0;
        key_ready = 1'b0;
        #1;
        test_reset();
        test_single_press();
        test_glitch();
        test_back_to_back();
        test_overrun();
        test_multi();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
